// File: rtl/relock_controller_pkg.sv
// Shared state encodings and constants for the relock supervisor.
package relock_controller_pkg;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;
  localparam logic [1:0] ST_ILLEGAL  = 2'd3;

  localparam logic [15:0] RELOCK_SAT = 16'hFFFF;

  // Release threshold may never sit above the acquire threshold.
  function automatic logic signed [15:0] smin16(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/relock_controller_boxcar_avg.sv
// Boxcar mean of the last 2^AVG_LOG2 signed samples; buffer and sum start at zero,
// so the mean ramps up from 0 after reset. Output is registered (one cycle).
module relock_boxcar_avg #(
  parameter int AVG_LOG2 = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [15:0] sample_in,
  output logic signed [15:0] mean_out
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = 16 + AVG_LOG2;

  logic [N-1:0][15:0]       buf_q, buf_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d, shifted;
  logic signed [15:0]       mean_q, mean_d;

  always_comb begin
    buf_d   = {buf_q[N-2:0], sample_in};
    sum_d   = sum_q + SUM_W'(sample_in) - SUM_W'($signed(buf_q[N-1]));
    shifted = sum_d >>> AVG_LOG2;
    mean_d  = shifted[15:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_q  <= '0;
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      buf_q  <= buf_d;
      sum_q  <= sum_d;
      mean_q <= mean_d;
    end
  end

  assign mean_out = mean_q;

endmodule

// File: rtl/relock_controller.sv
// Lock-state supervisor: hysteresis thresholds with confirm/dropout timers driving PID
// enable, sweep hold, status and a saturating lock-loss counter. Define RELOCK_AVG_EN
// to compare a boxcar mean instead of the raw sample (one extra cycle of latency).
module relock_controller
  import relock_controller_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 100_000_000,
  parameter int DROP_CYCLES    = 16,
  parameter int CNT_W          = 28,
  parameter int AVG_LOG2       = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               enable_in,
  input  logic signed [15:0] trans_in,
  input  logic signed [15:0] thr_hi_in,
  input  logic signed [15:0] thr_lo_in,
  output logic               pid_on_out,
  output logic               sweep_hold_out,
  output logic               locked_out,
  output logic               acquiring_out,
  output logic               unlocked_out,
  output logic [1:0]         state_out,
  output logic [15:0]        relock_count_out
);

  localparam int DROP_W = $clog2(DROP_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CONF_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_CYCLES - 1);

  logic signed [15:0] sample_q, sample_d, cmp_val, thr_lo_eff;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   conf_q, conf_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [15:0]        relock_q, relock_d;
  logic               pid_on_q, pid_on_d, locked_q, locked_d;
  logic               acq_q, acq_d, unl_q, unl_d;
  logic               above_hi, below_lo;

`ifdef RELOCK_AVG_EN
  relock_boxcar_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .sample_in (sample_q),
    .mean_out  (cmp_val)
  );
`else
  assign cmp_val = sample_q;
`endif

  assign thr_lo_eff = smin16(thr_lo_in, thr_hi_in);
  assign above_hi   = cmp_val >= thr_hi_in;
  assign below_lo   = cmp_val < thr_lo_eff;

  always_comb begin
    sample_d = trans_in;
    state_d  = state_q;
    conf_d   = conf_q;
    drop_d   = drop_q;
    relock_d = relock_q;
    if (!enable_in) begin
      state_d = ST_UNLOCKED;
      conf_d  = '0;
      drop_d  = '0;
    end else begin
      case (state_q)
        ST_UNLOCKED: begin
          conf_d = '0;
          drop_d = '0;
          if (above_hi) state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (below_lo) begin
            state_d = ST_UNLOCKED;
            conf_d  = '0;
          end else if (conf_q == CONF_LAST) begin
            state_d = ST_LOCKED;
            conf_d  = '0;
            drop_d  = '0;
          end else begin
            conf_d = conf_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!below_lo) begin
            drop_d = '0;
          end else if (drop_q == DROP_LAST) begin
            state_d  = ST_UNLOCKED;
            drop_d   = '0;
            conf_d   = '0;
            relock_d = (relock_q == RELOCK_SAT) ? relock_q : relock_q + 1'b1;
          end else begin
            drop_d = drop_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          conf_d  = '0;
          drop_d  = '0;
        end
      endcase
    end
    // Status flops follow the next state so outputs change on the same edge as state.
    pid_on_d = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
    locked_d = state_d == ST_LOCKED;
    acq_d    = state_d == ST_ACQUIRE;
    unl_d    = state_d == ST_UNLOCKED;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sample_q <= '0;
      state_q  <= ST_UNLOCKED;
      conf_q   <= '0;
      drop_q   <= '0;
      relock_q <= '0;
      pid_on_q <= 1'b0;
      locked_q <= 1'b0;
      acq_q    <= 1'b0;
      unl_q    <= 1'b1;
    end else begin
      sample_q <= sample_d;
      state_q  <= state_d;
      conf_q   <= conf_d;
      drop_q   <= drop_d;
      relock_q <= relock_d;
      pid_on_q <= pid_on_d;
      locked_q <= locked_d;
      acq_q    <= acq_d;
      unl_q    <= unl_d;
    end
  end

  assign pid_on_out       = pid_on_q;
  assign sweep_hold_out   = pid_on_q;
  assign locked_out       = locked_q;
  assign acquiring_out    = acq_q;
  assign unlocked_out     = unl_q;
  assign state_out        = state_q;
  assign relock_count_out = relock_q;

endmodule

// File: tb/tb_relock_controller.sv
// Directed + randomized bench for relock_controller (default build, raw-sample compare).
module tb_relock_controller;

  localparam int C = 8;
  localparam int D = 4;

  logic               clk_in = 1'b0;
  logic               rst_in, enable_in;
  logic signed [15:0] trans_in, thr_hi_in, thr_lo_in;
  logic               pid_on_out, sweep_hold_out, locked_out, acquiring_out, unlocked_out;
  logic [1:0]         state_out;
  logic [15:0]        relock_count_out;

  relock_controller #(.CONFIRM_CYCLES(C), .DROP_CYCLES(D), .CNT_W(28), .AVG_LOG2(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .trans_in         (trans_in),
    .thr_hi_in        (thr_hi_in),
    .thr_lo_in        (thr_lo_in),
    .pid_on_out       (pid_on_out),
    .sweep_hold_out   (sweep_hold_out),
    .locked_out       (locked_out),
    .acquiring_out    (acquiring_out),
    .unlocked_out     (unlocked_out),
    .state_out        (state_out),
    .relock_count_out (relock_count_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Reference: mode 0=unlocked 1=acquire 2=locked, counters as plain ints.
  int m_mode = 0, m_conf = 0, m_drop = 0, m_lost = 0, m_sample = 0;

  task automatic model_edge();
    int s, hi, lo;
    s  = m_sample;
    hi = int'(thr_hi_in);
    lo = int'(thr_lo_in);
    if (lo > hi) lo = hi;
    if (rst_in) begin
      m_mode = 0; m_conf = 0; m_drop = 0; m_lost = 0; m_sample = 0;
      return;
    end
    m_sample = int'(trans_in);
    if (!enable_in) begin
      m_mode = 0; m_conf = 0; m_drop = 0;
      return;
    end
    if (m_mode == 0) begin
      if (s >= hi) begin m_mode = 1; m_conf = 0; end
    end else if (m_mode == 1) begin
      if (s < lo) m_mode = 0;
      else if (m_conf + 1 == C) begin m_mode = 2; m_drop = 0; end
      else m_conf++;
    end else begin
      if (s < lo) begin
        m_drop++;
        if (m_drop == D) begin
          m_mode = 0; m_drop = 0; m_conf = 0;
          if (m_lost < 65535) m_lost++;
        end
      end else m_drop = 0;
    end
  endtask

  function automatic logic [22:0] pack_exp(input int mode, input int lost);
    logic [1:0] st;
    st = 2'(mode);
    return {mode != 0, mode != 0, mode == 2, mode == 1, mode == 0, st, 16'(lost)};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {pid_on_out, sweep_hold_out, locked_out, acquiring_out, unlocked_out,
            state_out, relock_count_out};
  endfunction

  task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk_in);
      model_edge();
      #1;
      check(tag, obs_vec(), pack_exp(m_mode, m_lost));
    end
  endtask

  task automatic expect_const(input string tag, input int mode, input int lost);
    check(tag, obs_vec(), pack_exp(mode, lost));
  endtask

  initial begin
    int v, len, sel;
    rst_in = 1'b1; enable_in = 1'b1; trans_in = 16'h0000;
    thr_hi_in = 16'h2000; thr_lo_in = 16'h1000;

    // 1: reset
    step(1, "reset");
    expect_const("reset_vals", 0, 0);
    rst_in = 1'b0;

    // 2: acquire after 2 edges, locked 8 edges later
    trans_in = 16'h3000;
    step(1, "acq_lat1");
    expect_const("still_unl", 0, 0);
    step(1, "acq_lat2");
    expect_const("acquire", 1, 0);
    step(C - 1, "confirm");
    expect_const("confirm_not_yet", 1, 0);
    step(1, "lock_edge");
    expect_const("locked", 2, 0);

    // 3: dropout needs DROP_CYCLES consecutive low samples
    trans_in = 16'h0800;
    step(3, "drop3");
    trans_in = 16'h1800;
    step(1, "drop_band");
    trans_in = 16'h0800;
    step(4, "drop4");
    expect_const("drop_not_yet", 2, 0);
    step(1, "drop_edge");
    expect_const("lock_lost", 0, 1);

    // 4: low sample during ACQUIRE aborts without counting
    trans_in = 16'h3000;
    step(2, "acq_again");
    expect_const("acquire2", 1, 1);
    trans_in = 16'h0800;
    step(2, "acq_abort");
    expect_const("acq_abort", 0, 1);

    // 5: hysteresis band and swapped thresholds
    trans_in = 16'h1800;
    step(50, "band_unl");
    expect_const("band_unl", 0, 1);
    trans_in = 16'h3000;
    step(10, "relock");
    expect_const("relocked", 2, 1);
    trans_in = 16'h1800;
    step(20, "band_lock");
    expect_const("band_lock", 2, 1);
    thr_lo_in = 16'h3000;
    step(3, "swap_lo");
    expect_const("swap_not_yet", 2, 1);
    step(1, "swap_drop");
    expect_const("swap_lost", 0, 2);
    thr_lo_in = 16'h1000;

    // 6: enable override and reset mid-ACQUIRE
    trans_in = 16'h3000;
    step(10, "lock3");
    expect_const("locked3", 2, 2);
    enable_in = 1'b0;
    step(1, "disable");
    expect_const("disabled", 0, 2);
    enable_in = 1'b1;
    step(4, "acq_mid");
    expect_const("acq_mid", 1, 2);
    rst_in = 1'b1;
    step(1, "rst_mid");
    expect_const("rst_mid", 0, 0);
    rst_in = 1'b0;

    // Randomized segments around the thresholds
    for (int seg = 0; seg < 200; seg++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 4)      v = int'($urandom_range(32'h2000, 32'h7FFF));
      else if (sel <= 6) v = int'($urandom_range(32'h1000, 32'h1FFF));
      else if (sel <= 8) v = int'($urandom_range(0, 32'h8FFF)) - 32'h8000;
      else begin
        case ($urandom_range(0, 2))
          0:       v = int'(thr_hi_in);
          1:       v = int'(thr_lo_in);
          default: v = int'(thr_lo_in) - 1;
        endcase
      end
      trans_in  = 16'(v);
      enable_in = ($urandom_range(0, 19) != 0);
      rst_in    = ($urandom_range(0, 49) == 0);
      thr_lo_in = ($urandom_range(0, 9) == 0) ? 16'h3000 : 16'h1000;
      len = int'($urandom_range(1, 12));
      step(len, "random");
      rst_in = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
